sipo: RTL and testbench
=======================

Name: sipo

Overview:
- Serial-In Parallel-Out deserializer. It is the receive-side counterpart of the team's PISO shift register in the DCSK datapath.
- It collects bits presented one per strobe on i_bit/i_shift and assembles them into WIDTH-bit words.
- Each completed word is presented on a registered valid/ready output port toward the demodulator back end.
- One holding register decouples word assembly from downstream acceptance; an overrun pulse flags lost words.

Parameters:
- WIDTH, 16, word width in bits; legal range 2..64.
- LSB_FIRST, 1, bit order. 1: first received bit lands in o_data[0] (matches the PISO transmit order). 0: first received bit lands in o_data[WIDTH-1].

Ports:
- i_clk  input  1  clock, rising edge.
- i_arst_n  input  1  reset, asynchronous, active-low.
- i_bit  input  1  serial data bit, sampled only when i_shift=1.
- i_shift  input  1  bit strobe; one bit is accepted per cycle while high.
- i_clear  input  1  synchronous resync: discards the partial word.
- o_data  output  WIDTH  completed word; stable while o_valid=1.
- o_valid  output  1  o_data holds an unconsumed word.
- i_ready  input  1  downstream accepts the word when o_valid & i_ready.
- o_busy  output  1  partial word in progress (bit count != 0).
- o_overrun  output  1  one-cycle pulse: a completed word was dropped.

Behaviour:
- Reset (async assert, sync-release use): shift register, bit counter, o_data, o_valid, o_overrun all 0; o_busy=0.
- Bit counter:
  - width $clog2(WIDTH); counts 0..WIDTH-1.
  - Increments on each accepted bit.
  - Wraps to 0 on the WIDTH-th bit (word completion). No other wrap.
- Shift-in:
  - LSB_FIRST=1: bit k of the word (k = counter value) is written into position k.
  - LSB_FIRST=0: bit k is written into position WIDTH-1-k.
  - Positions not yet written in the current word are don't-care internally, but are never visible on o_data.
- Completion:
  - Occurs on the edge where i_shift=1 and counter=WIDTH-1.
  - The full word, including the current i_bit, loads o_data on that same edge.
  - o_valid=1 from the next cycle. Latency from last bit strobe to o_valid is 1 cycle.
- Handshake:
  - Acceptance occurs on an edge where o_valid=1 and i_ready=1.
  - o_valid clears after acceptance unless a completion happens on the same edge.
  - o_data must not change while o_valid=1 and the word is not accepted.
  - i_ready while o_valid=0 has no effect.
- Simultaneous completion and acceptance: o_data loads the new word and o_valid stays 1. No overrun.
- Completion while o_valid=1 and i_ready=0:
  - The new word is dropped; o_data and o_valid are unchanged.
  - o_overrun=1 for exactly the next cycle.
  - The counter still wraps to 0, so framing is preserved.
- i_clear:
  - Counter goes to 0 and the partial word is discarded on the next edge.
  - The holding register, o_valid and the handshake are unaffected.
  - i_clear together with i_shift in the same cycle: clear wins and the bit is discarded.
  - i_clear on a would-be completion edge: no word is produced.
- o_busy: combinational, (counter != 0).
- o_overrun: registered; deasserts the cycle after its pulse unless another overrun occurs.
- i_shift gaps of any length between bits are legal; the partial word is held indefinitely.
- Reset asserted mid-word or with o_valid=1: everything clears immediately. The partial word and the held word are lost; no overrun is flagged.

Test Plan:
- WIDTH=16, LSB_FIRST=1: shift 16 bits of 0xA5C3, LSB first, back-to-back, with i_ready=1. Required: o_valid high for 1 cycle, one cycle after the 16th strobe; o_data=0xA5C3; o_busy=1 during bits 2..16, 0 after.
- Same stimulus with LSB_FIRST=0 and bits supplied MSB first. Required: o_data=0xA5C3. Then 0x0001 sent LSB first under LSB_FIRST=0. Required: o_data=0x8000.
- Backpressure: i_ready=0; send 0x1234 then 0xFFFF. Required: o_data stays 0x1234 with o_valid=1 throughout; o_overrun pulses once, 1 cycle after the 32nd strobe. Raise i_ready, then send 0x00FF. Required: o_data=0x00FF.
- Completion and acceptance on the same edge: o_valid=1 holding 0x1111, i_ready=1 exactly on the edge of the 16th bit of 0x2222. Required: o_valid stays 1, o_data=0x2222, no overrun.
- Resync: send 7 bits, assert i_clear together with an i_shift, then send 16 bits of 0xBEEF. Required: o_busy=0 after the clear; exactly one word, 0xBEEF, is produced.
- Reset: assert i_arst_n low mid-word and with o_valid=1. Required: o_valid, o_overrun, o_busy and o_data go to 0 immediately, without waiting for a clock edge. After release, a full 16-bit word is required before o_valid rises again.

Source files
------------

// File: rtl/sipo.sv
// Serial-in parallel-out deserializer for the DCSK receive path.
// Bits arrive one per i_shift strobe and are assembled into WIDTH-bit words.
// Each finished word is copied into a single holding register, which is
// offered downstream on a valid/ready port. A word that finishes while the
// holding register is still occupied is dropped, and o_overrun pulses.
module sipo #(
    parameter int WIDTH     = 16,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_arst_n,
    input  logic             i_bit,
    input  logic             i_shift,
    input  logic             i_clear,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_busy,
    output logic             o_overrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    cnt;
    logic [CW-1:0]    pos;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] word_next;
    logic             take;
    logic             done;
    logic             accept;

    // A clear in the same cycle as a strobe discards that bit.
    assign take   = i_shift & ~i_clear;
    assign done   = take & (cnt == LAST);
    assign accept = o_valid & i_ready;
    assign o_busy = (cnt != '0);

    // Word as it would look with the current bit merged in; on the final
    // bit this is the complete word that goes to the holding register.
    always_comb begin
        pos       = LSB_FIRST ? cnt : (LAST - cnt);
        word_next = sreg;
        word_next[pos] = i_bit;
    end

    // Bit counter and assembly register; counter wraps only on completion.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cnt  <= '0;
            sreg <= '0;
        end else if (i_clear) begin
            cnt <= '0;
        end else if (take) begin
            sreg <= word_next;
            cnt  <= done ? '0 : (cnt + CW'(1));
        end
    end

    // Holding register, valid/ready handshake and overrun pulse. A
    // completion landing on an accept edge refills the register directly.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= done & o_valid & ~i_ready;
            if (done && (!o_valid || i_ready)) begin
                o_data  <= word_next;
                o_valid <= 1'b1;
            end else if (accept) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo.sv
// Bench for sipo: two instances (LSB-first and MSB-first) share one stimulus
// stream and are checked every cycle against a bit-list model, plus directed
// scenarios with literal expected words.
module tb_sipo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_bit;
    logic        shift;
    logic        clear;
    logic        ready;

    logic [15:0] l_data, m_data_o;
    logic        l_valid, m_valid_o;
    logic        l_busy, m_busy_o;
    logic        l_ovr, m_ovr_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sipo #(.WIDTH(16), .LSB_FIRST(1'b1)) u_lsb (
        .i_clk(clk), .i_arst_n(rst_n), .i_bit(s_bit), .i_shift(shift),
        .i_clear(clear), .o_data(l_data), .o_valid(l_valid), .i_ready(ready),
        .o_busy(l_busy), .o_overrun(l_ovr)
    );

    sipo #(.WIDTH(16), .LSB_FIRST(1'b0)) u_msb (
        .i_clk(clk), .i_arst_n(rst_n), .i_bit(s_bit), .i_shift(shift),
        .i_clear(clear), .o_data(m_data_o), .o_valid(m_valid_o), .i_ready(ready),
        .o_busy(m_busy_o), .o_overrun(m_ovr_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the list of bits received for the current word, and per
    // instance the held word / valid / overrun state.
    int          m_cnt = 0;
    bit          m_bits [16];
    logic [15:0] md [2];
    bit          mv [2];
    bit          mo [2];
    bit          comp;
    logic [15:0] w;

    initial begin
        for (int i = 0; i < 2; i++) begin
            md[i] = '0; mv[i] = 1'b0; mo[i] = 1'b0;
        end
    end

    // Advance the model on each rising edge, then compare both instances.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt = 0;
            for (int i = 0; i < 2; i++) begin
                md[i] = '0; mv[i] = 1'b0; mo[i] = 1'b0;
            end
        end else begin
            comp = shift && !clear && (m_cnt == 15);
            if (shift && !clear) m_bits[m_cnt] = s_bit;
            for (int i = 0; i < 2; i++) begin
                w = '0;
                for (int k = 0; k < 16; k++) begin
                    if (i == 0) w[k] = m_bits[k];
                    else        w[15 - k] = m_bits[k];
                end
                mo[i] = 1'b0;
                if (comp) begin
                    if (!mv[i] || ready) begin
                        md[i] = w;
                        mv[i] = 1'b1;
                    end else begin
                        mo[i] = 1'b1;
                    end
                end else if (mv[i] && ready) begin
                    mv[i] = 1'b0;
                end
            end
            if (clear) m_cnt = 0;
            else if (shift) m_cnt = (m_cnt == 15) ? 0 : m_cnt + 1;
        end
        #1;
        chk("lsb_data",    l_data,    md[0]);
        chk("lsb_valid",   l_valid,   mv[0]);
        chk("lsb_overrun", l_ovr,     mo[0]);
        chk("lsb_busy",    l_busy,    m_cnt != 0);
        chk("msb_data",    m_data_o,  md[1]);
        chk("msb_valid",   m_valid_o, mv[1]);
        chk("msb_overrun", m_ovr_o,   mo[1]);
        chk("msb_busy",    m_busy_o,  m_cnt != 0);
    end

    // Drive the first n bits of w (MSB first when msb_first), then drop the strobe.
    task automatic send_word(input logic [15:0] w_in, input bit msb_first, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            s_bit = msb_first ? w_in[15 - k] : w_in[k];
            shift = 1'b1;
        end
        @(negedge clk);
        shift = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; s_bit = 1'b0; shift = 1'b0; clear = 1'b0; ready = 1'b0;
        #1;
        chk("reset_valid", l_valid, 1'b0);
        chk("reset_data",  l_data,  16'h0000);
        chk("reset_busy",  l_busy,  1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // LSB-first word with downstream always ready
        ready = 1'b1;
        send_word(16'hA5C3, 1'b0, 16);
        chk("t1_valid", l_valid, 1'b1);
        chk("t1_data",  l_data,  16'hA5C3);
        @(negedge clk);
        chk("t1_valid_drop", l_valid, 1'b0);
        chk("t1_busy_after", l_busy,  1'b0);

        // MSB-first supply: MSB instance rebuilds the word, LSB one reverses it
        send_word(16'hA5C3, 1'b1, 16);
        chk("t2_msb_data", m_data_o, 16'hA5C3);
        chk("t2_lsb_data", l_data,   16'hC3A5);
        @(negedge clk);
        send_word(16'h0001, 1'b0, 16);
        chk("t2_msb_0001", m_data_o, 16'h8000);
        chk("t2_lsb_0001", l_data,   16'h0001);
        @(negedge clk);

        // Backpressure: second word dropped with an overrun pulse
        ready = 1'b0;
        send_word(16'h1234, 1'b0, 16);
        send_word(16'hFFFF, 1'b0, 16);
        chk("t3_hold_data", l_data,  16'h1234);
        chk("t3_hold_vld",  l_valid, 1'b1);
        chk("t3_ovr_pulse", l_ovr,   1'b1);
        @(negedge clk);
        chk("t3_ovr_end",   l_ovr,   1'b0);
        chk("t3_still",     l_data,  16'h1234);
        ready = 1'b1;
        @(negedge clk);
        send_word(16'h00FF, 1'b0, 16);
        chk("t3_new_data",  l_data,  16'h00FF);
        @(negedge clk);

        // Completion and acceptance on the same edge
        ready = 1'b0;
        send_word(16'h1111, 1'b0, 16);
        send_word(16'h2222, 1'b0, 15);
        @(negedge clk);
        ready = 1'b1; s_bit = 1'b0; shift = 1'b1;
        @(negedge clk);
        shift = 1'b0;
        chk("t4_valid", l_valid, 1'b1);
        chk("t4_data",  l_data,  16'h2222);
        chk("t4_ovr",   l_ovr,   1'b0);
        @(negedge clk);

        // Resync: clear together with a strobe after 7 bits
        send_word(16'h007F, 1'b0, 7);
        @(negedge clk);
        clear = 1'b1; shift = 1'b1; s_bit = 1'b1;
        @(negedge clk);
        clear = 1'b0; shift = 1'b0;
        chk("t5_busy", l_busy, 1'b0);
        send_word(16'hBEEF, 1'b0, 16);
        chk("t5_data",  l_data,  16'hBEEF);
        chk("t5_valid", l_valid, 1'b1);
        @(negedge clk);

        // Asynchronous reset mid-word with a held word
        ready = 1'b0;
        send_word(16'h4321, 1'b0, 16);
        send_word(16'h00AA, 1'b0, 8);
        chk("t6_pre_busy",  l_busy,  1'b1);
        chk("t6_pre_valid", l_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", l_valid,  1'b0);
        chk("t6_rst_busy",  l_busy,   1'b0);
        chk("t6_rst_data",  l_data,   16'h0000);
        chk("t6_rst_ovr",   l_ovr,    1'b0);
        chk("t6_rst_mdata", m_data_o, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        send_word(16'h5A5A, 1'b0, 15);
        chk("t6_no_early", l_valid, 1'b0);
        @(negedge clk);
        s_bit = 1'b0; shift = 1'b1;
        @(negedge clk);
        shift = 1'b0;
        chk("t6_word_vld",  l_valid, 1'b1);
        chk("t6_word_data", l_data,  16'h5A5A);

        // Randomized traffic against the model
        repeat (3000) begin
            @(negedge clk);
            shift = ($urandom_range(0, 9) < 7);
            s_bit = $urandom_range(0, 1) == 1;
            clear = ($urandom_range(0, 49) == 0);
            ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        shift = 1'b0; clear = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
